piso_rr_sched: RTL and testbench



---
 rtl/piso_rr_sched.sv | 162 ++++++++++++++++
 tb/tb_piso_rr_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_rr_sched.sv
// Two-requester round-robin arbiter sharing one MSB-first serializer with framing strobes.
// Define PISO_RR_SCHED_PARITY_EN to append an even-parity bit after each frame.
module piso_rr_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             grant_id,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef PISO_RR_SCHED_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_SHIFT  = 2'd1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  // Holds the bits still to be sent after the one currently on so.
  logic [WIDTH-2:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_rr_ptr;
  logic             r_grant_id;
  logic             r_so;
  logic             r_so_valid;
  logic             r_frame_start;
  logic             r_busy;
`ifdef PISO_RR_SCHED_PARITY_EN
  logic             r_parity;
`endif

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_hs;
  logic             w_last;
  logic             w_so_nxt;
  logic             w_fs_nxt;
  logic [WIDTH-1:0] w_hs_data;

  // Round-robin arbitration; ready is only offered from IDLE and never while in reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n && (r_state == ST_IDLE)) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = r_rr_ptr;
        w_gnt1 = ~r_rr_ptr;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_hs       = w_gnt0 | w_gnt1;
  assign w_hs_data  = w_gnt1 ? req1_data : req0_data;
  assign w_last     = (r_bit_cnt == LAST_CNT);

  // Next state plus the serial bit and strobe to present in the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_so_nxt    = 1'b0;
    w_fs_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_state_nxt = ST_SHIFT;
          w_so_nxt    = w_hs_data[WIDTH-1];
          w_fs_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
`ifdef PISO_RR_SCHED_PARITY_EN
          w_state_nxt = ST_PARITY;
          w_so_nxt    = r_parity;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_state_nxt = ST_SHIFT;
          w_so_nxt    = r_shreg[WIDTH-2];
        end
      end
`ifdef PISO_RR_SCHED_PARITY_EN
      ST_PARITY: begin
        w_state_nxt = ST_IDLE;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_rr_ptr      <= 1'b1;
      r_grant_id    <= 1'b0;
      r_so          <= 1'b0;
      r_so_valid    <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
`ifdef PISO_RR_SCHED_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_so          <= w_so_nxt;
      r_so_valid    <= (w_state_nxt != ST_IDLE);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_frame_start <= w_fs_nxt;
      if (w_hs) begin
        r_shreg    <= w_hs_data[WIDTH-2:0];
        r_bit_cnt  <= '0;
        r_rr_ptr   <= w_gnt1;
        r_grant_id <= w_gnt1;
`ifdef PISO_RR_SCHED_PARITY_EN
        r_parity   <= ^w_hs_data;
`endif
      end else if (r_state == ST_SHIFT) begin
        r_shreg <= r_shreg << 1;
        if (!w_last) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign so          = r_so;
  assign so_valid    = r_so_valid;
  assign frame_start = r_frame_start;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;

endmodule

// File: tb/tb_piso_rr_sched.sv
// Self-checking bench for piso_rr_sched: vector table, corner sequences and a random run
// against a queue-based frame model. Honours PISO_RR_SCHED_PARITY_EN.
module tb_piso_rr_sched;
  localparam int W = 4;
`ifdef PISO_RR_SCHED_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = W + P;

  logic         clk;
  logic         rst_n;
  logic         v0, v1;
  logic [W-1:0] d0, d1;
  logic         req0_ready, req1_ready;
  logic         so, so_valid, frame_start, grant_id, busy;

  int checks;
  int failures;

  piso_rr_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_data(d1), .req1_ready(req1_ready),
    .so(so), .so_valid(so_valid), .frame_start(frame_start),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bits of the frame in flight, oldest first.
  bit m_q[$];
  int m_pos;
  bit m_ptr;
  bit m_gid;
  bit m_hs0, m_hs1;

  typedef struct {
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         gid;
    logic [W-1:0] word;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pos = 0;
    m_ptr = 1'b1;
    m_gid = 1'b0;
    m_hs0 = 1'b0;
    m_hs1 = 1'b0;
  endfunction

  task automatic exp_ready(output logic e0, output logic e1);
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst_n && m_q.size() == 0) begin
      if (v0 && v1) begin
        e0 = m_ptr;
        e1 = !m_ptr;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
  endtask

  task automatic model_step(input logic e0, input logic e1);
    logic [W-1:0] word;
    m_hs0 = e0 && v0;
    m_hs1 = e1 && v1;
    if (m_hs0 || m_hs1) begin
      word = m_hs1 ? d1 : d0;
      m_q.delete();
      for (int i = W - 1; i >= 0; i--) m_q.push_back(word[i]);
      if (P == 1) m_q.push_back(^word);
      m_pos = 0;
      m_gid = m_hs1;
      m_ptr = m_hs1;
    end else if (m_q.size() > 0) begin
      void'(m_q.pop_front());
      m_pos++;
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic tick();
    logic e0, e1;
    bit   nz;
    #1;
    exp_ready(e0, e1);
    chk("m_req0_ready", req0_ready, e0);
    chk("m_req1_ready", req1_ready, e1);
    @(posedge clk);
    model_step(e0, e1);
    @(negedge clk);
    #1;
    nz = (m_q.size() > 0);
    chk("m_so_valid", so_valid, nz);
    chk("m_so", so, nz ? m_q[0] : 1'b0);
    chk("m_frame_start", frame_start, nz && (m_pos == 0));
    chk("m_busy", busy, nz);
    chk("m_grant_id", grant_id, m_gid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, fs_cnt, nfr, idle_run;
    int gseq[3];
    logic [W-1:0] w;
    checks   = 0;
    failures = 0;

    tbl[0] = '{1'b1, 4'b1011, 1'b1, 4'b0110, 1'b0, 4'b1011};
    tbl[1] = '{1'b1, 4'b0101, 1'b1, 4'b0010, 1'b1, 4'b0010};
    tbl[2] = '{1'b1, 4'b0101, 1'b1, 4'b0010, 1'b0, 4'b0101};
    tbl[3] = '{1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100};
    tbl[4] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b1111};
    tbl[5] = '{1'b1, 4'b0001, 1'b1, 4'b1000, 1'b1, 4'b1000};
    tbl[6] = '{1'b0, 4'b0000, 1'b1, 4'b1110, 1'b1, 4'b1110};
    tbl[7] = '{1'b1, 4'b0000, 1'b1, 4'b1001, 1'b0, 4'b0000};

    // Reset with both requesters valid.
    rst_n = 1'b0;
    v0 = 1'b1; d0 = 4'b1011;
    v1 = 1'b1; d1 = 4'b0110;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_so", so, 1'b0);
    chk("rst_so_valid", so_valid, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req0_ready", req0_ready, 1'b1);
    chk("rel_req1_ready", req1_ready, 1'b0);

    // Vector table: one frame per row, checked bit by bit.
    for (int r = 0; r < 8; r++) begin
      v0 = tbl[r].v0; d0 = tbl[r].d0;
      v1 = tbl[r].v1; d1 = tbl[r].d1;
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 8) begin
        tick();
        n++;
      end
      if (n >= 8) begin
        checks++;
        failures++;
        $display("FAIL tbl_handshake_timeout row=%0d", r);
      end
      chk("tbl_grant_sel", req1_ready, tbl[r].gid);
      tick();
      v0 = 1'b0;
      v1 = 1'b0;
      w = tbl[r].word;
      for (int i = W - 1; i >= 0; i--) begin
        chk("tbl_so", so, w[i]);
        chk("tbl_frame_start", frame_start, i == W - 1);
        chk("tbl_grant_id", grant_id, tbl[r].gid);
        tick();
      end
      if (P == 1) begin
        chk("tbl_parity", so, ^w);
        chk("tbl_parity_fs", frame_start, 1'b0);
        tick();
      end
      chk("tbl_busy_end", busy, 1'b0);
      chk("tbl_so_valid_end", so_valid, 1'b0);
    end

    // req1 raised during a req0 frame waits for IDLE.
    v0 = 1'b1; d0 = 4'b1011;
    tick();
    v0 = 1'b0;
    v1 = 1'b1; d1 = 4'b0100;
    for (int k = 0; k < L; k++) begin
      #1;
      chk("late_r1_held", req1_ready, 1'b0);
      tick();
    end
    #1;
    chk("late_r1_idle_ready", req1_ready, 1'b1);
    tick();
    v1 = 1'b0;
    w = 4'b0100;
    for (int i = W - 1; i >= 0; i--) begin
      chk("late_so", so, w[i]);
      chk("late_grant_id", grant_id, 1'b1);
      tick();
    end
    if (P == 1) begin
      chk("late_parity", so, 1'b1);
      tick();
    end

    // One-cycle req0 pulse while busy must not start a frame.
    v1 = 1'b1; d1 = 4'b0011;
    tick();
    v1 = 1'b0;
    tick();
    v0 = 1'b1; d0 = 4'b1111;
    tick();
    v0 = 1'b0;
    cnt = 0;
    fs_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (so_valid) cnt++;
      if (frame_start) fs_cnt++;
      tick();
    end
    chki("pulse_bits", cnt, W - 2 + P);
    chki("pulse_fs", fs_cnt, 0);

    // Reset on the third bit of a frame, then both requesters valid continuously.
    v0 = 1'b1; d0 = 4'b1010;
    tick();
    v0 = 1'b0;
    tick();
    tick();
    chk("mid_so_valid_pre", so_valid, 1'b1);
    chk("mid_so_pre", so, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_so_valid", so_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_so", so, 1'b0);
    chk("mid_grant_id", grant_id, 1'b0);
    model_reset();
    v0 = 1'b1; d0 = 4'b0101;
    v1 = 1'b1; d1 = 4'b0010;
    #1;
    chk("mid_req0_ready", req0_ready, 1'b0);
    chk("mid_req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nfr = 0;
    idle_run = 0;
    for (int k = 0; k < 3 * (L + 1); k++) begin
      tick();
      if (k == 0) begin
        chk("post_rst_fs", frame_start, 1'b1);
        chk("post_rst_gid", grant_id, 1'b0);
      end
      if (frame_start) begin
        if (nfr > 0) chki("alt_gap", idle_run, 1);
        if (nfr < 3) gseq[nfr] = int'(grant_id);
        nfr++;
        idle_run = 0;
      end else if (!so_valid) begin
        idle_run++;
      end
    end
    chki("alt_frames", nfr, 3);
    chki("alt_g0", gseq[0], 0);
    chki("alt_g1", gseq[1], 1);
    chki("alt_g2", gseq[2], 0);
    v0 = 1'b0;
    v1 = 1'b0;
    for (int k = 0; k < L + 2; k++) tick();

    // Randomized traffic against the model, including withdrawn requests.
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (m_hs0) begin
        v0 = 1'($urandom_range(0, 1));
        d0 = W'($urandom);
      end else if (!v0) begin
        if ($urandom_range(0, 2) == 0) begin
          v0 = 1'b1;
          d0 = W'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        v0 = 1'b0;
      end
      if (m_hs1) begin
        v1 = 1'($urandom_range(0, 1));
        d1 = W'($urandom);
      end else if (!v1) begin
        if ($urandom_range(0, 2) == 0) begin
          v1 = 1'b1;
          d1 = W'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        v1 = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
